gcd_lcm: RTL and testbench

- Downstream consumer of the gcd FSM.
- Takes the original operand pair plus the gcd's 32-bit result and computes LCM = (ia / g) * ib.
- Division: sequential restoring divide. Multiply: sequential shift-add. Output is a 64-bit LCM with a start/busy/done handshake.
- Top level starts this block once the gcd has reached its final state.

---
 rtl/gcd_lcm.sv | 174 +++++++++++++++++
 tb/tb_gcd_lcm.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_lcm.sv
// LCM from an operand pair and its gcd: restoring divide ia/g, then shift-add multiply by ib.
// Optional err output (g==0 or g not dividing ia) is enabled by defining GCD_LCM_ERR_EN.
module gcd_lcm #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   ia,
    input  logic [W-1:0]   ib,
    input  logic [W-1:0]   g,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result
`ifdef GCD_LCM_ERR_EN
   ,output logic           err
`endif
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_MUL,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    // div_q holds the dividend and fills with quotient bits as it shifts out.
    logic [W-1:0]   div_q, div_d;
    logic [W-1:0]   g_q, g_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] result_q, result_d;
`ifdef GCD_LCM_ERR_EN
    logic           err_pend_q, err_pend_d;
    logic           err_q, err_d;
`endif

    logic [W:0]     rem_shift;
    logic [W:0]     rem_diff;
    logic           rem_ge;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop; blocking here would create races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            g_q        <= '0;
            rem_q      <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
`ifdef GCD_LCM_ERR_EN
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            g_q        <= g_d;
            rem_q      <= rem_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
`ifdef GCD_LCM_ERR_EN
            err_pend_q <= err_pend_d;
            err_q      <= err_d;
`endif
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        g_d        = g_q;
        rem_d      = rem_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
`ifdef GCD_LCM_ERR_EN
        err_pend_d = err_pend_q;
        err_d      = err_q;
`endif

        // rem < g always holds, so the W+1-bit difference is negative exactly when rem' < g.
        rem_shift = {rem_q, div_q[W-1]};
        rem_diff  = rem_shift - {1'b0, g_q};
        rem_ge    = ~rem_diff[W];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    div_d   = ia;
                    mcand_d = {{W{1'b0}}, ib};
                    g_d     = g;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                rem_d = '0;
                acc_d = '0;
                cnt_d = '0;
`ifdef GCD_LCM_ERR_EN
                err_pend_d = (g_q == '0);
`endif
                // Zero operands run one empty multiply step, so the result lands at edge 3.
                if (div_q == '0 || mcand_q == '0 || g_q == '0) begin
                    div_d   = '0;
                    cnt_d   = CNT_LAST;
                    state_d = S_MUL;
                end else begin
                    state_d = S_DIV;
                end
            end

            S_DIV: begin
                rem_d = rem_ge ? rem_diff[W-1:0] : rem_shift[W-1:0];
                div_d = {div_q[W-2:0], rem_ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_MUL;
`ifdef GCD_LCM_ERR_EN
                    err_pend_d = (rem_d != '0);
`endif
                end
            end

            S_MUL: begin
                acc_d   = acc_q + (div_q[0] ? mcand_q : '0);
                div_d   = div_q >> 1;
                mcand_d = mcand_q << 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    result_d = acc_d;
`ifdef GCD_LCM_ERR_EN
                    err_d    = err_pend_q;
`endif
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
`ifdef GCD_LCM_ERR_EN
    assign err    = err_q;
`endif

endmodule

// File: tb/tb_gcd_lcm.sv
// Self-checking bench for gcd_lcm: directed scenarios plus randomized jobs against
// a cycle-level behavioural model. Define GCD_LCM_ERR_EN to also exercise err.
module tb_gcd_lcm;

    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   ia, ib, g;
    logic           busy, done;
    logic [2*W-1:0] result;
`ifdef GCD_LCM_ERR_EN
    logic           err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    gcd_lcm #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ia     (ia),
        .ib     (ib),
        .g      (g),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef GCD_LCM_ERR_EN
       ,.err    (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x = a;
        logic [31:0] y = b;
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [63:0] lcm_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] gg);
        if (a == 0 || b == 0 || gg == 0) return 64'd0;
        return 64'(a / gg) * 64'(b);
    endfunction

    function automatic logic err_ref(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] gg);
        if (gg == 0) return 1'b1;
        if (a == 0 || b == 0) return 1'b0;
        return (a % gg) != 0;
    endfunction

    // Behavioural model: a job occupies a fixed number of edges, then shows done for one cycle.
    localparam int M_IDLE = 0, M_WORK = 1, M_DONE = 2;
    int          m_phase = M_IDLE;
    int          m_left  = 0;
    logic [63:0] m_res   = '0;
    logic        m_err   = 1'b0;
    logic [63:0] m_pend_res;
    logic        m_pend_err;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= M_IDLE;
            m_res   <= '0;
            m_err   <= 1'b0;
        end else begin
            case (m_phase)
                M_IDLE: if (start) begin
                    m_phase    <= M_WORK;
                    m_left     <= (ia == 0 || ib == 0 || g == 0) ? 2 : 2 * W + 1;
                    m_pend_res <= lcm_ref(ia, ib, g);
                    m_pend_err <= err_ref(ia, ib, g);
                end
                M_WORK: if (m_left == 1) begin
                    m_phase <= M_DONE;
                    m_res   <= m_pend_res;
                    m_err   <= m_pend_err;
                end else begin
                    m_left <= m_left - 1;
                end
                default: m_phase <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", busy, m_phase != M_IDLE);
            check("model_done", done, m_phase == M_DONE);
            check("model_result", result, m_res);
`ifdef GCD_LCM_ERR_EN
            check("model_err", err, m_err);
`endif
        end
    end

    // Runs one job from IDLE; checks busy after edge 1, the done edge, the result and the idle return.
    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] gg,
                           input logic [63:0] exp_res, input int exp_lat, input string tag);
        int got = 0;
        @(negedge clk);
        ia = a; ib = b; g = gg; start = 1'b1;
        for (int e = 1; e <= 90; e++) begin
            @(negedge clk);
            if (e == 1) begin
                start = 1'b0;
                ia = $urandom; ib = $urandom; g = $urandom;
                check({tag, "_busy_edge1"}, busy, 1'b1);
            end
            if (done && got == 0) begin
                got = e;
                check({tag, "_result"}, result, exp_res);
            end else if (got != 0 && e == got + 1) begin
                check({tag, "_done_pulse"}, done, 1'b0);
                check({tag, "_busy_after"}, busy, 1'b0);
                break;
            end
        end
        check({tag, "_done_edge"}, got, exp_lat);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check({tag, "_idle_timeout"}, 1'b1, 1'b0);
    endtask

    initial begin
        int got;
        int n_done;
        bit seen;
        logic [31:0] a, b, gg, k;

        rst = 1'b1; start = 1'b0; ia = '0; ib = '0; g = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, 64'd0);

        run_job(32'd12, 32'd18, 32'd6, 64'd36, 66, "t1");
        run_job(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 64'hFFFF_FFFD_0000_0002, 66, "t2");
        run_job(32'd0, 32'd7, 32'd7, 64'd0, 3, "t3");
`ifdef GCD_LCM_ERR_EN
        check("t3_err", err, 1'b0);
`endif

        // Second start while busy must be ignored.
        @(negedge clk);
        ia = 32'd21; ib = 32'd6; g = 32'd3; start = 1'b1;
        got = 0;
        for (int e = 1; e <= 90; e++) begin
            @(negedge clk);
            if (e == 1) start = 1'b0;
            if (e == 9) begin start = 1'b1; ia = 32'd5; end
            if (e == 10) start = 1'b0;
            if (done && got == 0) begin
                got = e;
                check("t4_result", result, 64'd42);
            end else if (got != 0 && e == got + 1) break;
        end
        check("t4_done_edge", got, 66);

        // start held high: the next job is taken at the first edge back in IDLE.
        @(negedge clk);
        ia = 32'd12; ib = 32'd18; g = 32'd6; start = 1'b1;
        got = 0;
        for (int e = 1; e <= 90; e++) begin
            @(negedge clk);
            if (done && got == 0) got = e;
            if (got != 0 && e == got + 1) check("t4_held_idle_gap", busy, 1'b0);
            if (got != 0 && e == got + 2) begin
                check("t4_held_reaccept", busy, 1'b1);
                break;
            end
        end
        check("t4_held_done_edge", got, 66);
        start = 1'b0;
        wait_idle("t4");

        // Reset mid-division discards the job.
        @(negedge clk);
        ia = 32'd12; ib = 32'd18; g = 32'd6; start = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            if (e == 1) start = 1'b0;
            if (e == 19) rst = 1'b1;
        end
        rst = 1'b0;
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_done", done, 1'b0);
        check("t5_rst_result", result, 64'd0);
        n_done = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("t5_no_done", n_done, 0);

`ifdef GCD_LCM_ERR_EN
        run_job(32'd10, 32'd4, 32'd3, 64'd12, 66, "t6a");
        check("t6a_err", err, 1'b1);
        run_job(32'd5, 32'd5, 32'd0, 64'd0, 3, "t6b");
        check("t6b_err", err, 1'b1);
`endif

        // Randomized jobs with random start pulses while busy; the model checks every cycle.
        for (int j = 0; j < 40; j++) begin
            case ($urandom_range(0, 3))
                0: begin
                    k = $urandom_range(1, 1000);
                    a = $urandom_range(1, 1000) * k;
                    b = $urandom_range(1, 1000) * k;
                    gg = gcd_ref(a, b);
                end
                1: begin
                    a = $urandom; b = $urandom;
                    gg = gcd_ref(a, b);
                end
                2: begin
                    a = $urandom; b = $urandom;
                    gg = $urandom_range(1, 50);
                end
                default: begin
                    a = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
                    b = $urandom_range(0, 1) == 0 ? 32'd0 : $urandom;
                    gg = $urandom_range(0, 1) == 0 ? 32'd0 : $urandom_range(1, 9);
                end
            endcase
            @(negedge clk);
            ia = a; ib = b; g = gg; start = 1'b1;
            seen = 1'b0;
            for (int e = 1; e <= 100; e++) begin
                @(negedge clk);
                if (seen && !busy) break;
                if (done) begin
                    start = 1'b0;
                    seen = 1'b1;
                end else if (!seen) begin
                    start = ($urandom_range(0, 3) == 0);
                    ia = $urandom; ib = $urandom; g = $urandom;
                end
            end
            start = 1'b0;
            check("rand_job_done_seen", seen, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
